// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet/UDP datapath constants and the payload FIFO storage word.
package eth_pkg;
  localparam int AXIS_DATA_WIDTH = 8;
  localparam int UDP_FIFO_DEPTH = 2048;
  typedef struct packed {
    logic user;
    logic last;
    logic [AXIS_DATA_WIDTH-1:0] data;
  } fifo_word_t;
endpackage

// File: rtl/udp_fifo_ram.sv
// udp_fifo_ram: simple dual-port RAM, one write port and one registered read port.
module udp_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/udp_payload_frame_fifo.sv
// udp_payload_frame_fifo: store-and-forward UDP payload FIFO with overflow frame drop.
// Define UDP_FIFO_DROP_BAD_FRAME_EN to discard frames flagged bad (tuser on tlast).
module udp_payload_frame_fifo import eth_pkg::*; #(
  parameter int DEPTH = UDP_FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tuser,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic                       status_good_frame,
  output logic                       status_bad_frame,
  output logic                       status_overflow
);
  typedef logic [ADDR_WIDTH:0] ptr_t;
  localparam ptr_t PTR_FULL = ptr_t'(DEPTH);
  localparam ptr_t PTR_ONE = ptr_t'(1);
  ptr_t wr_ptr_cur_q, wr_ptr_cur_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fe_ptr_q, fe_ptr_d;
  logic drop_frame_q, drop_frame_d, ram_valid_q, ram_valid_d, out_valid_q, out_valid_d;
  logic good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
  fifo_word_t out_q, out_d, ram_rdata, ram_wdata;
  logic accept, full, drop, bad, last, we, load_out, rd_en;
  // rd_ptr tracks bytes handed off downstream, so words still in the read pipeline stay reserved
  always_comb begin
    accept = s_axis_tvalid & s_axis_tready;
    full = (wr_ptr_cur_q - rd_ptr_q) == PTR_FULL;
    drop = accept & (drop_frame_q | full);
    we = accept & ~drop;
    last = accept & s_axis_tlast;
`ifdef UDP_FIFO_DROP_BAD_FRAME_EN
    bad = s_axis_tuser;
`else
    bad = 1'b0;
`endif
    wr_ptr_cur_d = (last & (drop | bad)) ? wr_ptr_q : we ? wr_ptr_cur_q + PTR_ONE : wr_ptr_cur_q;
    wr_ptr_d = (last & ~drop & ~bad) ? wr_ptr_cur_q + PTR_ONE : wr_ptr_q;
    drop_frame_d = ~last & (drop | drop_frame_q);
    ovf_d = last & drop;
    bad_d = last & ~drop & bad;
    good_d = last & ~drop & ~bad;
    load_out = ram_valid_q & (~out_valid_q | m_axis_tready);
    rd_en = (wr_ptr_q != fe_ptr_q) & (~ram_valid_q | load_out);
    ram_valid_d = rd_en | (ram_valid_q & ~load_out);
    out_valid_d = load_out | (out_valid_q & ~m_axis_tready);
    out_d = load_out ? ram_rdata : out_q;
    fe_ptr_d = rd_en ? fe_ptr_q + PTR_ONE : fe_ptr_q;
    rd_ptr_d = (out_valid_q & m_axis_tready) ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ram_wdata = '{user: s_axis_tuser, last: s_axis_tlast, data: s_axis_tdata};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_cur_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fe_ptr_q <= '0;
      drop_frame_q <= 1'b0;
      ram_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_q <= '0;
      good_q <= 1'b0;
      bad_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_cur_q <= wr_ptr_cur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fe_ptr_q <= fe_ptr_d;
      drop_frame_q <= drop_frame_d;
      ram_valid_q <= ram_valid_d;
      out_valid_q <= out_valid_d;
      out_q <= out_d;
      good_q <= good_d;
      bad_q <= bad_d;
      ovf_q <= ovf_d;
    end
  end
  udp_fifo_ram #(.DEPTH(DEPTH), .WIDTH($bits(fifo_word_t))) u_ram (
    .clock(clock),
    .we(we),
    .waddr(wr_ptr_cur_q[ADDR_WIDTH-1:0]),
    .wdata(ram_wdata),
    .re(rd_en),
    .raddr(fe_ptr_q[ADDR_WIDTH-1:0]),
    .rdata(ram_rdata)
  );
  assign s_axis_tready = ~reset;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata = out_q.data;
  assign m_axis_tlast = out_q.last;
  assign m_axis_tuser = out_q.user;
  assign status_good_frame = good_q;
  assign status_bad_frame = bad_q;
  assign status_overflow = ovf_q;
endmodule

// File: tb/tb_udp_payload_frame_fifo.sv
// tb_udp_payload_frame_fifo: scoreboard bench with a byte-count reference model of the frame FIFO.
module tb_udp_payload_frame_fifo;
  localparam int DEPTH = 16;
`ifdef UDP_FIFO_DROP_BAD_FRAME_EN
  localparam bit BAD_EN = 1'b1;
`else
  localparam bit BAD_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] s_data = '0, m_data;
  logic s_valid = 1'b0, s_last = 1'b0, s_user = 1'b0, s_ready;
  logic m_valid, m_ready = 1'b0, m_last, m_user;
  logic st_good, st_bad, st_ovf;
  udp_payload_frame_fifo #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .status_good_frame(st_good), .status_bad_frame(st_bad), .status_overflow(st_ovf)
  );
  always #5 clock = ~clock;
  int n_cmp = 0, n_err = 0;
  logic [9:0] exp_q[$], fr[$];
  logic [2:0] st_q[$];
  int committed = 0, consumed = 0, cur = 0, rmode = 1;
  bit dropping = 1'b0, hs_last = 1'b0, tgl = 1'b1;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Storage occupancy is bytes committed or pending minus bytes already handed downstream.
  task automatic model_beat(logic [7:0] d, bit l, bit u);
    if (!dropping && committed + cur - consumed == DEPTH) dropping = 1'b1;
    if (!dropping) begin
      fr.push_back({u, l, d});
      cur++;
    end
    if (l) begin
      if (dropping) st_q.push_back(3'b001);
      else if (BAD_EN && u) st_q.push_back(3'b010);
      else begin
        foreach (fr[i]) exp_q.push_back(fr[i]);
        committed += cur;
        st_q.push_back(3'b100);
      end
      fr.delete();
      cur = 0;
      dropping = 1'b0;
    end
  endtask
  task automatic step(bit v, logic [7:0] d, bit l, bit u);
    @(negedge clock);
    consumed += int'(hs_last);
    m_ready = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 : rmode == 2 ? tgl : 1'($urandom_range(0, 1));
    if (rmode == 2) tgl = ~tgl;
    s_valid = v;
    s_data = d;
    s_last = l;
    s_user = u;
    if (v) model_beat(d, l, u);
    #1 hs_last = m_valid & m_ready;
  endtask
  task automatic send_frame(int n, logic [7:0] first, bit u);
    for (int i = 0; i < n; i++) step(1'b1, first + 8'(i), i == n - 1, u && i == n - 1);
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && n < 3000) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    n_cmp++;
    if (n >= 3000) begin
      n_err++;
      $display("FAIL drain: %0d beats and %0d status events still expected", exp_q.size(), st_q.size());
    end
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b1;
      s_valid = 1'b0;
      #1 check("rst_tready", 32'(s_ready), 0);
    end
    @(negedge clock);
    check("rst_outputs", {m_valid, m_data, m_last, m_user, st_good, st_bad, st_ovf}, 0);
    reset = 1'b0;
    committed = 0;
    consumed = 0;
    cur = 0;
    dropping = 1'b0;
    hs_last = 1'b0;
    fr.delete();
    #1 check("post_rst_tready", 32'(s_ready), 1);
  endtask
  logic stall_prev = 1'b0;
  logic [9:0] held;
  always @(negedge clock) begin
    #2;
    if (reset) stall_prev = 1'b0;
    else begin
      if (m_valid && stall_prev) check("stall_hold", {m_user, m_last, m_data}, held);
      stall_prev = m_valid && !m_ready;
      held = {m_user, m_last, m_data};
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_extra: got %0h expected no beat", {m_user, m_last, m_data});
        end else check("out_beat", {m_user, m_last, m_data}, exp_q.pop_front());
      end
      if (st_good || st_bad || st_ovf) begin
        if (st_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL status_extra: got %b expected none", {st_good, st_bad, st_ovf});
        end else check("status", {st_good, st_bad, st_ovf}, st_q.pop_front());
      end
    end
  end
  initial begin
    do_reset(2);
    rmode = 1;
    send_frame(4, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("latency_lo", 32'(m_valid), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("latency_hi", 32'(m_valid), 1);
    drain();
    rmode = 0;
    send_frame(10, 8'h20, 1'b0);
    send_frame(8, 8'h40, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b0, 1'b0);
    rmode = 1;
    drain();
    send_frame(5, 8'h10, 1'b1);
    send_frame(3, 8'hA0, 1'b0);
    drain();
    rmode = 2;
    tgl = 1'b1;
    send_frame(6, 8'h60, 1'b0);
    drain();
    rmode = 1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    do_reset(1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    drain();
    send_frame(1, 8'h99, 1'b0);
    drain();
    rmode = 0;
    send_frame(DEPTH, 8'h80, 1'b0);
    rmode = 1;
    drain();
    rmode = 0;
    send_frame(DEPTH + 1, 8'hC0, 1'b0);
    rmode = 1;
    drain();
    for (int f = 0; f < 40; f++)
      for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), i == 6, 1'b0);
    drain();
    rmode = 3;
    for (int f = 0; f < 300; f++) begin
      int len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'($urandom), i == len - 1, i == len - 1 && $urandom_range(0, 3) == 0);
      end
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
